// File: rtl/accum_sequencer.sv
// Sequences one signed accumulator through a reduction pass: clear, stream N terms, capture
// the final sum and sticky overflow, and hand the result off on a valid/ready handshake.
module accum_sequencer #(
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned ACCUM_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 10
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [CNT_WIDTH-1:0]          num_terms_i,
    input  logic                          abort_i,
    output logic                          busy_o,
    input  logic                          term_valid_i,
    output logic                          term_ready_o,
    input  logic signed [IN_WIDTH-1:0]    term_data_i,
    output logic                          acc_en_o,
    output logic                          acc_clear_o,
    output logic                          acc_valid_o,
    output logic signed [IN_WIDTH-1:0]    acc_data_o,
    input  logic signed [ACCUM_WIDTH-1:0] acc_sum_i,
    input  logic                          acc_overflow_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic signed [ACCUM_WIDTH-1:0] result_o,
    output logic                          overflow_o
);

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StDone} state_e;

    state_e                        state_q;
    logic [CNT_WIDTH-1:0]          n_q;
    logic [CNT_WIDTH-1:0]          cnt_q;
    logic                          ovf_q;
    logic signed [ACCUM_WIDTH-1:0] result_q;
    logic                          overflow_q;
    logic                          abort_active;
    logic                          term_hs;

    assign abort_active = abort_i && (state_q != StIdle);
    assign term_hs      = term_valid_i && term_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            n_q        <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else if (abort_active) begin
            // Captured result is left untouched so the previous pass stays readable.
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        n_q     <= num_terms_i;
                        state_q <= StClear;
                    end
                end
                StClear: begin
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= (n_q != '0) ? StAccum : StDrain;
                end
                StAccum: begin
                    ovf_q <= ovf_q | acc_overflow_i;
                    if (term_hs) begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == n_q - CNT_WIDTH'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // The last add's overflow flag only becomes visible here.
                    result_q   <= acc_sum_i;
                    overflow_q <= ovf_q | acc_overflow_i;
                    state_q    <= StDone;
                end
                StDone: begin
                    if (result_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        term_ready_o   = 1'b0;
        acc_en_o       = 1'b0;
        acc_clear_o    = 1'b0;
        acc_valid_o    = 1'b0;
        acc_data_o     = '0;
        result_valid_o = 1'b0;
        unique case (state_q)
            StIdle: ;
            StClear: begin
                acc_en_o    = 1'b1;
                acc_clear_o = 1'b1;
            end
            StAccum: begin
                acc_en_o     = 1'b1;
                term_ready_o = 1'b1;
                acc_valid_o  = term_valid_i;
                acc_data_o   = term_data_i;
            end
            StDrain: acc_en_o = 1'b1;
            StDone:  result_valid_o = 1'b1;
            default: ;
        endcase
        if (abort_active) begin
            term_ready_o   = 1'b0;
            acc_en_o       = 1'b1;
            acc_clear_o    = 1'b1;
            acc_valid_o    = 1'b0;
            acc_data_o     = '0;
            result_valid_o = 1'b0;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign result_o   = result_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: a vector table of fixed passes, hand-written abort/reset sequences,
// and randomized passes checked against a plain-arithmetic model of the reduction.
module tb_accum_sequencer;
    localparam int IW = 16;
    localparam int AW = 16;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 start_i = 1'b0;
    logic [CW-1:0]        num_terms_i = '0;
    logic                 abort_i = 1'b0;
    logic                 busy_o;
    logic                 term_valid_i = 1'b0;
    logic                 term_ready_o;
    logic signed [IW-1:0] term_data_i = '0;
    logic                 acc_en_o, acc_clear_o, acc_valid_o;
    logic signed [IW-1:0] acc_data_o;
    logic signed [AW-1:0] acc_sum_i;
    logic                 acc_overflow_i;
    logic                 result_valid_o;
    logic                 result_ready_i = 1'b0;
    logic signed [AW-1:0] result_o;
    logic                 overflow_o;

    accum_sequencer #(.IN_WIDTH(IW), .ACCUM_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .num_terms_i(num_terms_i),
        .abort_i(abort_i), .busy_o(busy_o), .term_valid_i(term_valid_i),
        .term_ready_o(term_ready_o), .term_data_i(term_data_i), .acc_en_o(acc_en_o),
        .acc_clear_o(acc_clear_o), .acc_valid_o(acc_valid_o), .acc_data_o(acc_data_o),
        .acc_sum_i(acc_sum_i), .acc_overflow_i(acc_overflow_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_o(result_o), .overflow_o(overflow_o)
    );

    // External accumulator: wrapping add, per-add overflow flag held until the next add/clear.
    logic signed [AW-1:0] m_sum = '0;
    logic                 m_ovf = 1'b0;
    int                   m_next;
    assign m_next = int'(m_sum) + int'(acc_data_o);
    always @(posedge clk) begin
        if (acc_en_o) begin
            if (acc_clear_o) begin
                m_sum <= '0;
                m_ovf <= 1'b0;
            end else if (acc_valid_o) begin
                m_sum <= AW'(m_next);
                m_ovf <= (m_next > 32767) || (m_next < -32768);
            end
        end
    end
    assign acc_sum_i      = m_sum;
    assign acc_overflow_i = m_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    logic signed [IW-1:0] tq[$];
    logic [15:0] g_sum;
    logic        g_ovf;
    int          g_lat, g_hs, g_stalls, g_clears, g_pt_bad;
    bit          g_saw_ready, g_stable;

    // Sum of the pass's terms with 16-bit wraparound; overflow if any partial sum leaves range.
    task automatic model(input int n, output logic [15:0] s, output logic o);
        int acc;
        acc = 0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += int'(tq[i]);
            if (acc > 32767) begin
                acc -= 65536;
                o = 1'b1;
            end else if (acc < -32768) begin
                acc += 65536;
                o = 1'b1;
            end
        end
        s = 16'(acc);
    endtask

    task automatic run_pass(input int n, input logic [15:0] vpat, input bit rnd,
                            input int rdy_delay);
        int edges, sent, acc_cyc;
        bit v;
        g_hs = 0; g_stalls = 0; g_clears = 0; g_pt_bad = 0; g_saw_ready = 0; g_stable = 1;
        sent = 0; acc_cyc = 0;
        @(negedge clk);
        start_i = 1'b1;
        num_terms_i = CW'(n);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        while (!result_valid_o && edges < 400) begin
            start_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            num_terms_i = CW'($urandom);
            if (term_ready_o) begin
                g_saw_ready = 1;
                v = rnd ? ($urandom_range(0, 9) < 7) : (acc_cyc < 16 ? vpat[acc_cyc] : 1'b1);
                acc_cyc++;
                if (!v) g_stalls++;
            end else begin
                v = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            term_valid_i = v;
            term_data_i = (sent < n) ? tq[sent] : IW'($urandom);
            #1;
            if (acc_clear_o) g_clears++;
            if (term_ready_o) begin
                if (acc_valid_o !== term_valid_i || acc_data_o !== term_data_i) g_pt_bad++;
            end else if (acc_valid_o !== 1'b0 || acc_data_o !== '0) begin
                g_pt_bad++;
            end
            if (term_valid_i && term_ready_o) begin
                g_hs++;
                sent++;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start_i = 1'b0;
        term_valid_i = 1'b0;
        g_sum = result_o;
        g_ovf = overflow_o;
        g_lat = edges;
        for (int i = 0; i < rdy_delay; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!result_valid_o || result_o !== g_sum || overflow_o !== g_ovf || !busy_o)
                g_stable = 0;
        end
        result_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready_i = 1'b0;
        if (busy_o !== 1'b0 || result_valid_o !== 1'b0) g_stable = 0;
    endtask

    task automatic check_common(input int n);
        check("handshakes", g_hs, n);
        check("clear_pulses", g_clears, 1);
        check("acc_passthru", g_pt_bad, 0);
        check("result_hold_release", 32'(g_stable), 32'd1);
        check("ready_seen", 32'(g_saw_ready), 32'(n != 0));
    endtask

    typedef struct {
        int           n;
        logic [15:0]  vpat;
        logic [3:0][15:0] t;
        logic [15:0]  exp_sum;
        logic         exp_ovf;
        int           exp_lat;
    } vec_t;

    vec_t vecs[7];
    logic [15:0] exp_sum, prev_sum;
    logic        exp_ovf;
    int          n_rand;
    bit          rv_seen;

    initial begin
        vecs[0] = '{4, 16'hFFFF, {16'hFFFE, 16'h000A, 16'hFFFD, 16'h0005}, 16'h000A, 1'b0, 7};
        vecs[1] = '{3, 16'hFFE9, {16'h0000, 16'hFFCE, 16'h00C8, 16'h0064}, 16'h00FA, 1'b0, 9};
        vecs[2] = '{3, 16'hFFFF, {16'h0000, 16'hFFFF, 16'h0001, 16'h7FFF}, 16'h7FFF, 1'b1, 6};
        vecs[3] = '{0, 16'hFFFF, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, 1'b0, 3};
        vecs[4] = '{2, 16'hFFFF, {16'h0000, 16'h0000, 16'hFFFF, 16'h8000}, 16'h7FFF, 1'b1, 5};
        vecs[5] = '{3, 16'hFFFF, {16'h0000, 16'h0001, 16'h0001, 16'h7FFF}, 16'h8001, 1'b1, 6};
        vecs[6] = '{1, 16'hFFFC, {16'h0000, 16'h0000, 16'h0000, 16'h1234}, 16'h1234, 1'b0, 6};

        #1;
        rst = 1'b1;
        start_i = 1'b1;
        term_valid_i = 1'b1;
        num_terms_i = CW'(5);
        term_data_i = 16'sh1234;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(term_ready_o), 32'd0);
        check("rst_acc_ctl", 32'({acc_en_o, acc_clear_o, acc_valid_o}), 32'd0);
        check("rst_acc_data", 32'(acc_data_o), 32'd0);
        check("rst_result_valid", 32'(result_valid_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        start_i = 1'b0;
        term_valid_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 7; i++) begin
            tq.delete();
            for (int k = 0; k < vecs[i].n; k++) tq.push_back(vecs[i].t[k]);
            run_pass(vecs[i].n, vecs[i].vpat, 1'b0, 0);
            check("vec_sum", 32'(g_sum), 32'(vecs[i].exp_sum));
            check("vec_ovf", 32'(g_ovf), 32'(vecs[i].exp_ovf));
            check("vec_latency", g_lat, vecs[i].exp_lat);
            check_common(vecs[i].n);
        end
        prev_sum = g_sum;

        // Abort after two of five terms.
        @(negedge clk);
        start_i = 1'b1;
        num_terms_i = CW'(5);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        term_valid_i = 1'b1;
        term_data_i = 16'sd3;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        abort_i = 1'b1;
        #1;
        check("abort_ctl", 32'({acc_en_o, acc_clear_o, term_ready_o, result_valid_o}),
              32'b1100);
        @(posedge clk);
        @(negedge clk);
        abort_i = 1'b0;
        term_valid_i = 1'b0;
        check("abort_idle", 32'(busy_o), 32'd0);
        rv_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (result_valid_o) rv_seen = 1;
        end
        check("abort_no_result", 32'(rv_seen), 32'd0);
        check("abort_result_kept", 32'(result_o), 32'(prev_sum));
        tq.delete();
        tq.push_back(16'sd7);
        run_pass(1, 16'hFFFF, 1'b0, 1);
        check("after_abort_sum", 32'(g_sum), 32'd7);
        check("after_abort_ovf", 32'(g_ovf), 32'd0);
        check_common(1);

        // Reset mid-pass drops the pass immediately.
        @(negedge clk);
        start_i = 1'b1;
        num_terms_i = CW'(3);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ctl", 32'({busy_o, term_ready_o, acc_en_o, result_valid_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", 32'(result_o), 32'd0);

        n_rand = 25;
        for (int p = 0; p < n_rand; p++) begin
            int n;
            n = $urandom_range(0, 20);
            tq.delete();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 1) == 1) tq.push_back(IW'($urandom));
                else tq.push_back(IW'($urandom_range(0, 200)) - 16'sd100);
            end
            model(n, exp_sum, exp_ovf);
            run_pass(n, 16'h0, 1'b1, $urandom_range(0, 3));
            check("rand_sum", 32'(g_sum), 32'(exp_sum));
            check("rand_ovf", 32'(g_ovf), 32'(exp_ovf));
            check("rand_latency", g_lat, n + 3 + g_stalls);
            check_common(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Controller that sequences one signed accumulator for an energy-monitor reduction pass. It accepts a start command with a term count, clears the accumulator, then streams exactly that many signed terms into it under a valid/ready handshake. It captures the final sum and a sticky overflow flag, and presents them on a result handshake. It sits between the term producer (spin × coupling products) and the accumulator instance, and owns that instance's en/clear/valid/data inputs.

## Interface
- IN_WIDTH, 16, term width (matches accumulator input)
- ACCUM_WIDTH, 32, accumulator/result width
- CNT_WIDTH, 10, term-count width; max pass length 2^CNT_WIDTH-1

- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  start pulse; sampled only in IDLE
- num_terms_i  in  CNT_WIDTH  terms in this pass; sampled with start_i
- abort_i  in  1  synchronous abort, highest priority after reset
- busy_o  out  1  high in every state except IDLE
- term_valid_i  in  1  upstream term valid
- term_ready_o  out  1  controller accepts a term
- term_data_i  in  IN_WIDTH signed  term value
- acc_en_o  out  1  accumulator enable
- acc_clear_o  out  1  accumulator clear
- acc_valid_o  out  1  accumulator input valid
- acc_data_o  out  IN_WIDTH signed  accumulator input data
- acc_sum_i  in  ACCUM_WIDTH signed  accumulator registered sum
- acc_overflow_i  in  1  accumulator registered per-add overflow flag
- result_valid_o  out  1  result available
- result_ready_i  in  1  result consumed
- result_o  out  ACCUM_WIDTH signed  captured sum
- overflow_o  out  1  sticky overflow for the captured pass

## Operation
- FSM states: IDLE, CLEAR, ACCUM, DRAIN, DONE.
- IDLE
  - All handshake outputs low.
  - On start_i: latch num_terms_i into n_q and go to CLEAR.
- CLEAR (1 cycle)
  - acc_en_o=1, acc_clear_o=1.
  - Term counter cnt_q←0, sticky ovf_q←0.
  - Next state: ACCUM if n_q≠0, else DRAIN (the result is the cleared value, 0).
- ACCUM
  - acc_en_o=1, term_ready_o=1.
  - acc_valid_o=term_valid_i and acc_data_o=term_data_i, combinational pass-through.
  - Handshake = term_valid_i & term_ready_o. Each handshake increments cnt_q.
  - The handshake with cnt_q==n_q-1 moves to DRAIN.
  - ovf_q |= acc_overflow_i every cycle.
- DRAIN (1 cycle)
  - acc_en_o=1, acc_valid_o=0, term_ready_o=0. The accumulator register now holds the final sum.
  - result_o←acc_sum_i, overflow_o←ovf_q|acc_overflow_i.
  - Next state: DONE.
- DONE
  - result_valid_o=1. result_o and overflow_o are held stable.
  - term_ready_o=0, acc_en_o=0.
  - On result_ready_i: go to IDLE.
- abort_i in any non-IDLE state
  - That cycle: acc_en_o=1, acc_clear_o=1, term_ready_o=0, result_valid_o=0.
  - Next state: IDLE. result_o and overflow_o keep their previous values.
- start_i outside IDLE is ignored.
- cnt_q never exceeds n_q. It does not wrap within a pass.
- acc_data_o is 0 whenever the state is not ACCUM.

## Timing
- Reset values: busy_o=0, term_ready_o=0, acc_en_o=0, acc_clear_o=0, acc_valid_o=0, acc_data_o=0, result_valid_o=0, result_o=0, overflow_o=0. FSM state is IDLE.
- Reset mid-pass: the pass is abandoned with no result. The accumulator is cleared by the next CLEAR.
- Stall-free pass, start_i at cycle t:
  - CLEAR at t+1.
  - Terms accepted t+2 … t+N+1.
  - DRAIN at t+N+2.
  - result_valid_o from t+N+3.
- Each upstream stall cycle adds one cycle.
- N=0: CLEAR t+1, DRAIN t+2, result_valid_o t+3.
- Back-to-back passes:
  - result_ready_i in DONE at cycle d → IDLE at d+1.
  - The earliest new start_i is accepted at d+1.
- Overflow flags from any add in the pass, including the last (seen in DRAIN), are captured. The overflow flag cleared in CLEAR is never counted.

## Test plan
- Reset held with start_i=1 and term_valid_i=1 → all outputs 0 and no state change. After release, IDLE with busy_o=0.
- num_terms_i=4, terms 5, −3, 10, −2, no stalls, result_ready_i=1 → result_o=10, overflow_o=0. result_valid_o at t+7, busy_o low at t+8.
- num_terms_i=3, term_valid_i toggling 1,0,0,1,0,1 → exactly 3 handshakes, result_valid_o at t+9, sum correct. cnt_q never exceeds 3.
- ACCUM_WIDTH=16, terms 0x7FFF then 0x0001 then −1 → overflow_o=1, result_o=0x7FFF (wrapped sum).
- num_terms_i=0 → result_o=0 and result_valid_o at t+3; no term_ready_o pulse.
- abort_i after 2 of 5 terms → acc_clear_o pulse that cycle, IDLE next, result_valid_o never rises. A following 1-term pass with value 7 → result_o=7.
